mandelbrot_ctrl_s_axi: RTL and testbench
========================================

Name: mandelbrot_ctrl_s_axi

Overview:
- AXI4-Lite slave register file behind the mandelbrot kernel's s_axi_control port.
- Holds the scalar argument ctrl_length and the 64-bit global-memory pointer a.
- Implements the ap_ctrl_hs start/done/idle/ready handshake toward the kernel datapath, plus interrupt enable/status registers.
- Host software and the control VIP program the kernel through this block and poll it for completion.

Parameters:
- C_S_AXI_ADDR_WIDTH, 12, byte address width of the control interface.
- C_S_AXI_DATA_WIDTH, 32, data width. Only 32 is supported.

Ports:
- ap_clk  in  1  kernel clock. All logic is on this single clock.
- ap_rst_n  in  1  reset, asynchronous assert, active-low.
- awvalid/awready  in/out  1/1  write address handshake
- awaddr  in  C_S_AXI_ADDR_WIDTH  write byte address
- wvalid/wready  in/out  1/1  write data handshake
- wdata  in  32  write data
- wstrb  in  4  byte enables
- bvalid/bready  out/in  1/1  write response handshake
- bresp  out  2  always 2'b00
- arvalid/arready  in/out  1/1  read address handshake
- araddr  in  C_S_AXI_ADDR_WIDTH  read byte address
- rvalid/rready  out/in  1/1  read data handshake
- rdata  out  32  read data
- rresp  out  2  always 2'b00
- ap_start  out  1  start request to the datapath
- ap_done  in  1  one-cycle completion pulse from the datapath
- ap_idle  in  1  datapath idle level
- ap_ready  in  1  one-cycle pulse: datapath has accepted its arguments
- ctrl_length  out  32  scalar argument
- a  out  64  global-memory base pointer
- interrupt  out  1  level interrupt

Behaviour:
- Register map (addr[11:2] decoded; addr[1:0] ignored):
  - 0x000 AP_CTRL: bit0 ap_start (RW), bit1 ap_done (clear-on-read), bit2 ap_idle (RO, live input), bit3 ap_ready (RO, live input), bit7 auto_restart (RW). Other bits read 0.
  - 0x004 GIE: bit0 global interrupt enable.
  - 0x008 IER: bit0 enables the done source, bit1 enables the ready source.
  - 0x00C ISR: bit0 done, bit1 ready. Writing 1 to a bit toggles it.
  - 0x010 ctrl_length.
  - 0x018 a[31:0].
  - 0x01C a[63:32].
  - Any other address: writes are ignored; reads return 0.
- Write FSM: WRIDLE -> WRDATA -> WRRESP -> WRIDLE.
  - WRIDLE: awready=1; latches awaddr on handshake.
  - WRDATA: wready=1; register updates on the W handshake clock edge, honouring wstrb per byte.
  - WRRESP: bvalid=1 and held until bready.
  - AW is not accepted again until the B handshake completes.
- Read FSM: RDIDLE -> RDDATA -> RDIDLE.
  - RDIDLE: arready=1.
  - On the AR handshake, rdata is registered and rvalid=1 on the next cycle.
  - rdata and rvalid are held stable until rready.
- Reset (async, any time, including mid-transaction):
  - All registers clear; FSMs return to idle.
  - bvalid=rvalid=0, rdata=0, ap_start=0, ctrl_length=0, a=0, interrupt=0.
  - awready and arready are 0 while ap_rst_n=0 and become 1 on the first ap_clk edge after deassertion.
  - Any in-flight transfer is dropped with no response.
- ap_start:
  - Set the cycle after a W handshake to 0x000 with wdata[0]=1 and wstrb[0]=1.
  - Cleared on an ap_ready pulse unless auto_restart=1.
  - Writing 0 has no effect.
- ap_done status:
  - Bit1 is sticky: set by an ap_done pulse, cleared by an AR handshake to 0x000.
  - The read returns the pre-clear value.
  - If a set and a clear occur in the same cycle, set wins.
- ISR:
  - bit0 sets on ap_done & IER[0]; bit1 sets on ap_ready & IER[1].
  - If a hardware set and a toggle-write occur in the same cycle, the bit ends at 1.
- interrupt = GIE[0] & (ISR[0] | ISR[1]), registered (one-cycle latency).
- Reads and writes proceed concurrently and independently; a same-address read/write collision returns the old value.

Test Plan:
- Write 0x010 = 0xFFFFFFFF, then read 0x010 -> rdata=0xFFFFFFFF, rresp=0, bresp=0; ctrl_length=0xFFFFFFFF.
- Write 0x018 = 0x12345000 and 0x01C = 0xDEADBEEF -> a=0xDEADBEEF12345000; read 0x040 -> 0.
- Write 0x000 = 0x1 -> ap_start=1 one cycle after the W handshake. Pulse ap_ready -> ap_start=0 the next cycle. Repeat with 0x000 = 0x81 -> ap_start remains 1 after ap_ready.
- Pulse ap_done with ap_idle=1 -> first read of 0x000 = 0x06, second read = 0x04. Pulse ap_done in the same cycle as the read's AR handshake -> second read still shows bit1=1.
- GIE=1, IER=1, pulse ap_done -> interrupt=1 two cycles after the pulse. Write ISR=0x1 -> interrupt=0. Pulse ap_ready with IER[1]=0 -> no interrupt.
- Write 0x010 = 0xAABBCCDD with wstrb=4'b0101 over 0xFFFFFFFF -> 0xFFBBFFDD.
- Assert ap_rst_n=0 while bvalid=1 awaits bready -> bvalid=0 immediately, all registers 0. After deassertion a new write completes normally.

Source files
------------

// File: rtl/mandelbrot_ctrl_s_axi_if.sv
// AXI4-Lite bus bundle for the mandelbrot kernel control port.
// The master drives requests; the slave drives ready/response fields.
interface mandelbrot_ctrl_s_axi_if #(
    parameter int ADDR_W = 12
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/mandelbrot_ctrl_s_axi.sv
// AXI4-Lite control register file for the mandelbrot kernel:
// ap_ctrl_hs handshake, interrupts, ctrl_length and pointer a.
module mandelbrot_ctrl_s_axi #(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    mandelbrot_ctrl_s_axi_if.slave       s_axi,
    output logic                         o_ap_start,
    input  logic                         i_ap_done,
    input  logic                         i_ap_idle,
    input  logic                         i_ap_ready,
    output logic [31:0]                  o_ctrl_length,
    output logic [63:0]                  o_a,
    output logic                         o_interrupt
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int WW = AW - 2;

    localparam logic [WW-1:0] A_CTRL = WW'(0);
    localparam logic [WW-1:0] A_GIE  = WW'(1);
    localparam logic [WW-1:0] A_IER  = WW'(2);
    localparam logic [WW-1:0] A_ISR  = WW'(3);
    localparam logic [WW-1:0] A_LEN  = WW'(4);
    localparam logic [WW-1:0] A_ALO  = WW'(6);
    localparam logic [WW-1:0] A_AHI  = WW'(7);

    typedef enum logic [1:0] {
        WRIDLE, WRDATA, WRRESP, WRRESET
    } wstate_t;

    typedef enum logic [1:0] {
        RDIDLE, RDDATA, RDRESET
    } rstate_t;

    wstate_t       r_wstate, w_wnext;
    rstate_t       r_rstate, w_rnext;
    logic [WW-1:0] r_waddr;
    logic [WW-1:0] w_raddr;
    logic [DW-1:0] r_rdata, w_rdata;
    logic [31:0]   w_wmask;
    logic          w_aw_hs, w_w_hs, w_ar_hs;
    logic          w_wr_ctrl, w_wr_isr;

    logic          r_ap_start, r_auto_restart, r_ap_done;
    logic          r_gie, r_int;
    logic [1:0]    r_ier, r_isr;
    logic [31:0]   r_len, r_a_lo, r_a_hi;

    assign w_aw_hs = (r_wstate == WRIDLE) & s_axi.awvalid;
    assign w_w_hs  = (r_wstate == WRDATA) & s_axi.wvalid;
    assign w_ar_hs = (r_rstate == RDIDLE) & s_axi.arvalid;
    assign w_raddr = s_axi.araddr[AW-1:2];

    assign w_wmask = {{8{s_axi.wstrb[3]}}, {8{s_axi.wstrb[2]}},
                      {8{s_axi.wstrb[1]}}, {8{s_axi.wstrb[0]}}};

    assign w_wr_ctrl = w_w_hs & (r_waddr == A_CTRL) & s_axi.wstrb[0];
    assign w_wr_isr  = w_w_hs & (r_waddr == A_ISR) & s_axi.wstrb[0];

    assign s_axi.awready = (r_wstate == WRIDLE);
    assign s_axi.wready  = (r_wstate == WRDATA);
    assign s_axi.bvalid  = (r_wstate == WRRESP);
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = (r_rstate == RDIDLE);
    assign s_axi.rvalid  = (r_rstate == RDDATA);
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = 2'b00;

    assign o_ap_start    = r_ap_start;
    assign o_ctrl_length = r_len;
    assign o_a           = {r_a_hi, r_a_lo};
    assign o_interrupt   = r_int;

    // Reset parks both FSMs in a non-idle state so ready stays low.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wstate <= WRRESET;
            r_rstate <= RDRESET;
        end else begin
            r_wstate <= w_wnext;
            r_rstate <= w_rnext;
        end
    end

    always_comb begin
        w_wnext = r_wstate;
        unique case (r_wstate)
            WRIDLE:  if (s_axi.awvalid) w_wnext = WRDATA;
            WRDATA:  if (s_axi.wvalid)  w_wnext = WRRESP;
            WRRESP:  if (s_axi.bready)  w_wnext = WRIDLE;
            WRRESET: w_wnext = WRIDLE;
            default: w_wnext = WRIDLE;
        endcase
    end

    always_comb begin
        w_rnext = r_rstate;
        unique case (r_rstate)
            RDIDLE:  if (s_axi.arvalid) w_rnext = RDDATA;
            RDDATA:  if (s_axi.rready)  w_rnext = RDIDLE;
            RDRESET: w_rnext = RDIDLE;
            default: w_rnext = RDIDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (w_raddr)
            A_CTRL: begin
                w_rdata[0] = r_ap_start;
                w_rdata[1] = r_ap_done;
                w_rdata[2] = i_ap_idle;
                w_rdata[3] = i_ap_ready;
                w_rdata[7] = r_auto_restart;
            end
            A_GIE:   w_rdata[0]   = r_gie;
            A_IER:   w_rdata[1:0] = r_ier;
            A_ISR:   w_rdata[1:0] = r_isr;
            A_LEN:   w_rdata      = r_len;
            A_ALO:   w_rdata      = r_a_lo;
            A_AHI:   w_rdata      = r_a_hi;
            default: w_rdata      = '0;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_waddr <= '0;
            r_rdata <= '0;
        end else begin
            if (w_aw_hs) r_waddr <= s_axi.awaddr[AW-1:2];
            if (w_ar_hs) r_rdata <= w_rdata;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_len  <= '0;
            r_a_lo <= '0;
            r_a_hi <= '0;
        end else if (w_w_hs) begin
            case (r_waddr)
                A_LEN: r_len  <= (s_axi.wdata & w_wmask) | (r_len & ~w_wmask);
                A_ALO: r_a_lo <= (s_axi.wdata & w_wmask) | (r_a_lo & ~w_wmask);
                A_AHI: r_a_hi <= (s_axi.wdata & w_wmask) | (r_a_hi & ~w_wmask);
                default: ;
            endcase
        end
    end

    // A start write outranks the same-cycle ap_ready clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_ap_start     <= 1'b0;
            r_auto_restart <= 1'b0;
            r_ap_done      <= 1'b0;
        end else begin
            if (w_wr_ctrl && s_axi.wdata[0])
                r_ap_start <= 1'b1;
            else if (i_ap_ready)
                r_ap_start <= r_auto_restart;
            if (w_wr_ctrl)
                r_auto_restart <= s_axi.wdata[7];
            if (i_ap_done)
                r_ap_done <= 1'b1;
            else if (w_ar_hs && (w_raddr == A_CTRL))
                r_ap_done <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_gie <= 1'b0;
            r_ier <= 2'b00;
            r_isr <= 2'b00;
            r_int <= 1'b0;
        end else begin
            if (w_w_hs && (r_waddr == A_GIE) && s_axi.wstrb[0])
                r_gie <= s_axi.wdata[0];
            if (w_w_hs && (r_waddr == A_IER) && s_axi.wstrb[0])
                r_ier <= s_axi.wdata[1:0];
            if (i_ap_done && r_ier[0])
                r_isr[0] <= 1'b1;
            else if (w_wr_isr)
                r_isr[0] <= r_isr[0] ^ s_axi.wdata[0];
            if (i_ap_ready && r_ier[1])
                r_isr[1] <= 1'b1;
            else if (w_wr_isr)
                r_isr[1] <= r_isr[1] ^ s_axi.wdata[1];
            r_int <= r_gie & (r_isr[0] | r_isr[1]);
        end
    end
endmodule

// File: tb/tb_mandelbrot_ctrl_s_axi.sv
// Directed bench for the mandelbrot AXI4-Lite control block.
// Expected values are hand-computed constants.
module tb_mandelbrot_ctrl_s_axi;
    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [31:0] ctrl_length;
    logic [63:0] a;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;

    mandelbrot_ctrl_s_axi_if #(.ADDR_W(12)) bus ();

    mandelbrot_ctrl_s_axi #(
        .C_S_AXI_ADDR_WIDTH(12),
        .C_S_AXI_DATA_WIDTH(32)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .s_axi         (bus),
        .o_ap_start    (ap_start),
        .i_ap_done     (ap_done),
        .i_ap_idle     (ap_idle),
        .i_ap_ready    (ap_ready),
        .o_ctrl_length (ctrl_length),
        .o_a           (a),
        .o_interrupt   (irq)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic axi_wr(input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit hold_b);
        int n;
        @(negedge ap_clk);
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
        n = 0;
        while (!bus.awready && n < 100) begin @(negedge ap_clk); n++; end
        if (n >= 100) check("aw_timeout", 0, 1);
        @(negedge ap_clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        n = 0;
        while (!bus.wready && n < 100) begin @(negedge ap_clk); n++; end
        if (n >= 100) check("w_timeout", 0, 1);
        @(negedge ap_clk);
        bus.wvalid = 1'b0;
        if (!hold_b) begin
            bus.bready = 1'b1;
            n = 0;
            while (!bus.bvalid && n < 100) begin @(negedge ap_clk); n++; end
            if (n >= 100) check("b_timeout", 0, 1);
            check("bresp", 64'(bus.bresp), 0);
            @(negedge ap_clk);
            bus.bready = 1'b0;
        end
    endtask

    task automatic axi_rd(input logic [11:0] addr, output logic [31:0] data);
        int n;
        @(negedge ap_clk);
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        n = 0;
        while (!bus.arready && n < 100) begin @(negedge ap_clk); n++; end
        if (n >= 100) check("ar_timeout", 0, 1);
        @(negedge ap_clk);
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        n = 0;
        while (!bus.rvalid && n < 100) begin @(negedge ap_clk); n++; end
        if (n >= 100) check("r_timeout", 0, 1);
        data = bus.rdata;
        check("rresp", 64'(bus.rresp), 0);
        @(negedge ap_clk);
        bus.rready = 1'b0;
    endtask

    task automatic pulse(input int which);
        @(negedge ap_clk);
        if (which == 0) ap_done = 1'b1;
        else ap_ready = 1'b1;
        @(negedge ap_clk);
        ap_done  = 1'b0;
        ap_ready = 1'b0;
    endtask

    logic [31:0] rd;
    int n;

    initial begin
        ap_rst_n    = 1'b0;
        ap_done     = 1'b0;
        ap_idle     = 1'b0;
        ap_ready    = 1'b0;
        bus.awvalid = 1'b0;
        bus.awaddr  = '0;
        bus.wvalid  = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0;
        bus.araddr  = '0;
        bus.rready  = 1'b0;

        repeat (3) @(negedge ap_clk);
        check("rst_awready", 64'(bus.awready), 0);
        check("rst_arready", 64'(bus.arready), 0);
        check("rst_bvalid", 64'(bus.bvalid), 0);
        check("rst_rvalid", 64'(bus.rvalid), 0);
        check("rst_rdata", 64'(bus.rdata), 0);
        check("rst_start", 64'(ap_start), 0);
        check("rst_len", 64'(ctrl_length), 0);
        check("rst_a", a, 0);
        check("rst_irq", 64'(irq), 0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("awready_up", 64'(bus.awready), 1);
        check("arready_up", 64'(bus.arready), 1);

        // Scalar argument and pointer
        axi_wr(12'h010, 32'hFFFF_FFFF, 4'hF, 1'b0);
        axi_rd(12'h010, rd);
        check("len_rd", 64'(rd), 64'hFFFF_FFFF);
        check("len_port", 64'(ctrl_length), 64'hFFFF_FFFF);
        axi_wr(12'h018, 32'h1234_5000, 4'hF, 1'b0);
        axi_wr(12'h01C, 32'hDEAD_BEEF, 4'hF, 1'b0);
        check("a_port", a, 64'hDEAD_BEEF_1234_5000);
        axi_rd(12'h01C, rd);
        check("a_hi_rd", 64'(rd), 64'hDEAD_BEEF);
        axi_rd(12'h040, rd);
        check("unmapped_rd", 64'(rd), 0);

        // Byte strobes
        axi_wr(12'h010, 32'hAABB_CCDD, 4'b0101, 1'b0);
        check("strb_port", 64'(ctrl_length), 64'hFFBB_FFDD);
        axi_rd(12'h012, rd);
        check("strb_rd", 64'(rd), 64'hFFBB_FFDD);

        // ap_start handshake
        check("start_pre", 64'(ap_start), 0);
        axi_wr(12'h000, 32'h1, 4'hF, 1'b0);
        check("start_set", 64'(ap_start), 1);
        pulse(1);
        check("start_clr", 64'(ap_start), 0);
        axi_wr(12'h000, 32'h81, 4'hF, 1'b0);
        check("start_ar", 64'(ap_start), 1);
        pulse(1);
        check("start_keep", 64'(ap_start), 1);
        axi_rd(12'h000, rd);
        check("ctrl_ar_rd", 64'(rd), 64'h81);
        axi_wr(12'h000, 32'h0, 4'hF, 1'b0);
        check("start_wr0", 64'(ap_start), 1);
        pulse(1);
        check("start_clr2", 64'(ap_start), 0);

        // ap_done status, clear-on-read
        ap_idle = 1'b1;
        pulse(0);
        axi_rd(12'h000, rd);
        check("done_rd1", 64'(rd), 64'h06);
        axi_rd(12'h000, rd);
        check("done_rd2", 64'(rd), 64'h04);

        // done pulse coincident with the clearing AR handshake
        @(negedge ap_clk);
        bus.arvalid = 1'b1;
        bus.araddr  = 12'h000;
        ap_done     = 1'b1;
        @(negedge ap_clk);
        bus.arvalid = 1'b0;
        ap_done     = 1'b0;
        bus.rready  = 1'b1;
        n = 0;
        while (!bus.rvalid && n < 100) begin @(negedge ap_clk); n++; end
        if (n >= 100) check("r_timeout", 0, 1);
        check("coll_rd", 64'(bus.rdata), 64'h04);
        @(negedge ap_clk);
        bus.rready = 1'b0;
        axi_rd(12'h000, rd);
        check("coll_rd2", 64'(rd), 64'h06);
        axi_rd(12'h000, rd);
        check("coll_rd3", 64'(rd), 64'h04);

        // Interrupts
        axi_wr(12'h004, 32'h1, 4'hF, 1'b0);
        axi_wr(12'h008, 32'h1, 4'hF, 1'b0);
        check("irq_idle", 64'(irq), 0);
        pulse(0);
        check("irq_lat1", 64'(irq), 0);
        @(negedge ap_clk);
        check("irq_lat2", 64'(irq), 1);
        axi_rd(12'h00C, rd);
        check("isr_rd", 64'(rd), 64'h1);
        axi_wr(12'h00C, 32'h1, 4'hF, 1'b0);
        check("irq_ack", 64'(irq), 0);
        pulse(1);
        repeat (3) @(negedge ap_clk);
        check("irq_rdy_masked", 64'(irq), 0);
        axi_rd(12'h00C, rd);
        check("isr_rd2", 64'(rd), 64'h0);

        // Reset while a write response is pending
        axi_wr(12'h010, 32'h0000_1234, 4'hF, 1'b1);
        check("b_pending", 64'(bus.bvalid), 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        check("mid_bvalid", 64'(bus.bvalid), 0);
        check("mid_awready", 64'(bus.awready), 0);
        check("mid_len", 64'(ctrl_length), 0);
        check("mid_a", a, 0);
        check("mid_start", 64'(ap_start), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("re_awready", 64'(bus.awready), 1);
        axi_wr(12'h010, 32'h55AA_0011, 4'hF, 1'b0);
        axi_rd(12'h010, rd);
        check("post_rst_rd", 64'(rd), 64'h55AA_0011);
        axi_rd(12'h004, rd);
        check("post_rst_gie", 64'(rd), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
